ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 122 ++++++++++++
 tb/tb_ex_mem_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer, plus branch-taken
// pulse generation and a saturating taken-branch counter.
module ex_mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero_flag,
  input  logic              branch,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        rd_addr,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [4:0]        out_rd_addr,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc,
  output logic [15:0]       taken_count
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] sdata;
    logic [4:0]        rd;
    logic              rw;
    logic              mr;
    logic              mw;
  } pld_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  pld_t              main_pld_q, main_pld_d;
  pld_t              skid_pld_q, skid_pld_d;
  logic              branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0] branch_pc_q, branch_pc_d;
  logic [15:0]       taken_count_q, taken_count_d;

  pld_t in_pld;
  logic accept, drain, take;

  always_comb begin
    in_pld = {alu_result, store_data, rd_addr, reg_write, mem_read, mem_write};
    accept = in_valid & ~skid_valid_q;
    drain  = main_valid_q & out_ready;
    // A flushed accept must not leave any trace, including its branch pulse.
    take   = accept & branch & zero_flag & ~flush;

    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pld_d   = main_pld_q;
    skid_pld_d   = skid_pld_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      main_pld_d   = skid_pld_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || drain)) begin
      main_pld_d   = in_pld;
      main_valid_d = 1'b1;
    end else if (accept) begin
      skid_pld_d   = in_pld;
      skid_valid_d = 1'b1;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end

    branch_taken_d = take;
    branch_pc_d    = take ? branch_target : branch_pc_q;
    taken_count_d  = take ? sat_inc(taken_count_q) : taken_count_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_valid_q   <= 1'b0;
      skid_valid_q   <= 1'b0;
      main_pld_q     <= '0;
      skid_pld_q     <= '0;
      branch_taken_q <= 1'b0;
      branch_pc_q    <= '0;
      taken_count_q  <= '0;
    end else begin
      main_valid_q   <= main_valid_d;
      skid_valid_q   <= skid_valid_d;
      main_pld_q     <= main_pld_d;
      skid_pld_q     <= skid_pld_d;
      branch_taken_q <= branch_taken_d;
      branch_pc_q    <= branch_pc_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign in_ready       = ~skid_valid_q;
  assign out_valid      = main_valid_q;
  assign out_alu_result = main_pld_q.alu;
  assign out_store_data = main_pld_q.sdata;
  assign out_rd_addr    = main_pld_q.rd;
  assign out_reg_write  = main_pld_q.rw;
  assign out_mem_read   = main_pld_q.mr;
  assign out_mem_write  = main_pld_q.mw;
  assign branch_taken   = branch_taken_q;
  assign branch_pc      = branch_pc_q;
  assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: pass-through, skid back-pressure, branch
// pulse, flush, async reset and counter saturation.
module tb_ex_mem_stage;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, in_ready;
  logic [DATA_W-1:0] alu_result, branch_target, store_data;
  logic              zero_flag, branch;
  logic [4:0]        rd_addr;
  logic              reg_write, mem_read, mem_write;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_alu_result, out_store_data, branch_pc;
  logic [4:0]        out_rd_addr;
  logic              out_reg_write, out_mem_read, out_mem_write, branch_taken;
  logic [15:0]       taken_count;

  int n_chk = 0;
  int n_bad = 0;

  ex_mem_stage #(.DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .branch(branch),
    .branch_target(branch_target), .store_data(store_data),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .branch_taken(branch_taken), .branch_pc(branch_pc),
    .taken_count(taken_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; alu_result = '0; zero_flag = 0; branch = 0;
    branch_target = '0; store_data = '0; rd_addr = '0;
    reg_write = 0; mem_read = 0; mem_write = 0;
  endtask

  initial begin
    idle_inputs();
    out_ready = 1;
    reset = 1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_taken", branch_taken, 0);
    chk("rst_bpc", branch_pc, 0);
    chk("rst_count", taken_count, 0);
    chk("rst_alu", out_alu_result, 0);
    step();
    reset = 0;
    step();

    // single pass
    in_valid = 1; alu_result = 32'h10; rd_addr = 5; reg_write = 1; out_ready = 1;
    step();
    idle_inputs();
    chk("sp_valid", out_valid, 1);
    chk("sp_alu", out_alu_result, 32'h10);
    chk("sp_rd", out_rd_addr, 5);
    chk("sp_rw", out_reg_write, 1);
    step();
    chk("sp_valid_drop", out_valid, 0);

    // back-pressure into skid
    out_ready = 0;
    in_valid = 1; alu_result = 32'h1; store_data = 32'hA;
    step();
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_alu", out_alu_result, 32'h1);
    chk("bp_ready_a", in_ready, 1);
    alu_result = 32'h2; store_data = 32'hB;
    step();
    idle_inputs();
    chk("bp_ready_b", in_ready, 0);
    chk("bp_hold_a", out_alu_result, 32'h1);
    step();
    chk("bp_stable_alu", out_alu_result, 32'h1);
    chk("bp_stable_sd", out_store_data, 32'hA);
    out_ready = 1;
    step();
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_alu", out_alu_result, 32'h2);
    chk("bp_b_sd", out_store_data, 32'hB);
    chk("bp_ready_again", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // branch taken under back-pressure, then not-taken
    out_ready = 0;
    in_valid = 1; branch = 1; zero_flag = 1; branch_target = 32'h0040_0020;
    step();
    idle_inputs();
    chk("br_taken", branch_taken, 1);
    chk("br_pc", branch_pc, 32'h0040_0020);
    chk("br_count", taken_count, 1);
    step();
    chk("br_pulse_end", branch_taken, 0);
    chk("br_pc_hold", branch_pc, 32'h0040_0020);
    in_valid = 1; branch = 1; zero_flag = 0; branch_target = 32'h1234;
    step();
    idle_inputs();
    chk("nt_taken", branch_taken, 0);
    chk("nt_count", taken_count, 1);
    chk("nt_pc", branch_pc, 32'h0040_0020);
    chk("nt_skid_full", in_ready, 0);

    // flush with both entries full
    flush = 1; in_valid = 1; branch = 1; zero_flag = 1; branch_target = 32'h99;
    step();
    idle_inputs();
    chk("fl2_valid", out_valid, 0);
    chk("fl2_ready", in_ready, 1);
    chk("fl2_taken", branch_taken, 0);
    chk("fl2_count", taken_count, 1);

    // flush while a taken branch is being accepted
    in_valid = 1; alu_result = 32'h3;
    step();
    chk("fl1_main", out_valid, 1);
    flush = 1; in_valid = 1; branch = 1; zero_flag = 1; branch_target = 32'h77;
    step();
    idle_inputs();
    chk("fl1_valid", out_valid, 0);
    chk("fl1_ready", in_ready, 1);
    chk("fl1_taken", branch_taken, 0);
    chk("fl1_count", taken_count, 1);
    chk("fl1_pc", branch_pc, 32'h0040_0020);

    // async reset with both entries full
    in_valid = 1; alu_result = 32'h5; branch = 1; zero_flag = 1; branch_target = 32'h50;
    step();
    in_valid = 1; alu_result = 32'h6; branch = 0; zero_flag = 0;
    step();
    idle_inputs();
    chk("ar_pre_ready", in_ready, 0);
    chk("ar_pre_count", taken_count, 2);
    #2 reset = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_count", taken_count, 0);
    chk("ar_pc", branch_pc, 0);
    chk("ar_alu", out_alu_result, 0);
    #1 reset = 0;
    out_ready = 1;
    in_valid = 1; alu_result = 32'h7;
    step();
    idle_inputs();
    chk("ar_first_valid", out_valid, 1);
    chk("ar_first_alu", out_alu_result, 32'h7);
    step();
    chk("ar_drain", out_valid, 0);

    // saturation: continuous taken branches with the output always draining
    out_ready = 1;
    in_valid = 1; branch = 1; zero_flag = 1; branch_target = 32'hC0;
    repeat (65534) step();
    chk("sat_fffe", taken_count, 16'hFFFE);
    step();
    chk("sat_ffff", taken_count, 16'hFFFF);
    step();
    step();
    chk("sat_hold", taken_count, 16'hFFFF);
    chk("sat_pulse", branch_taken, 1);
    chk("sat_pc", branch_pc, 32'hC0);
    idle_inputs();
    step();
    chk("sat_idle_pulse", branch_taken, 0);
    chk("sat_idle_count", taken_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
